// File: rtl/enoc_switch_allocator.sv
// ----------------------------------------------------------------------------
// enoc_switch_allocator
//
// Switch allocator for one ENoC mesh/torus router. Each of the M output ports
// is shared among the N input queues by an independent round-robin arbiter.
// Grants are registered; the crossbar select and the queue pop (o_deq) are
// derived from the registered grant so that data and dequeue happen in the
// same cycle. A granted input keeps its output while the downstream enable is
// low, so no flit is lost or reordered under back-pressure.
//
// Optional feature (compile-time macro ENOC_ALLOC_PACKET_LOCK_EN):
//   defined   -> wormhole lock: an output stays with its holder from the first
//                non-tail transfer until the tail flit has been transferred.
//   undefined -> flit-level arbitration, i_tail is ignored, no lock state.
//
// Parameters:
//   N      number of input queues (requesters)
//   M      number of output ports (resources)
//   SEL_W  width of the per-output select index (derived from N)
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   i_req      [n]    input n has a head flit valid
//   i_req_out  [n][m] output requested by input n (lowest set bit wins)
//   i_tail     [n]    head flit of input n is a packet tail
//   i_en       [m]    downstream enable of output m
//   o_grant    [n][m] registered grant of output m to input n
//   o_sel      [m]    index of the input holding output m
//   o_sel_val  [m]    output m has a valid grant
//   o_deq      [n]    input n pops its queue this cycle
// ----------------------------------------------------------------------------
module enoc_switch_allocator #(
    parameter  int unsigned N     = 5,
    parameter  int unsigned M     = 5,
    localparam int unsigned SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [0:N-1]                i_req,
    input  logic [0:N-1][0:M-1]         i_req_out,
    input  logic [0:N-1]                i_tail,
    input  logic [0:M-1]                i_en,
    output logic [0:N-1][0:M-1]         o_grant,
    output logic [0:M-1][SEL_W-1:0]     o_sel,
    output logic [0:M-1]                o_sel_val,
    output logic [0:N-1]                o_deq
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:N-1][0:M-1]     r_grant;
    logic [0:M-1][SEL_W-1:0] r_sel;
    logic [0:M-1]            r_sel_val;
    logic [0:M-1][SEL_W-1:0] r_ptr;

    logic [0:N-1][0:M-1]     w_grant_d;
    logic [0:M-1][SEL_W-1:0] w_sel_d;
    logic [0:M-1]            w_sel_val_d;
    logic [0:M-1][SEL_W-1:0] w_ptr_d;

    // ------------------------------------------------------------------------
    // Request decode: one output per input, lowest index wins on multi-hot.
    // ------------------------------------------------------------------------
    logic [0:N-1][0:M-1] w_req_dec;

    always_comb begin
        logic v_hit;
        v_hit     = 1'b0;
        w_req_dec = '0;
        for (int n = 0; n < N; n++) begin
            v_hit = 1'b0;
            for (int m = 0; m < M; m++) begin
                if (i_req[n] && i_req_out[n][m] && !v_hit) begin
                    w_req_dec[n][m] = 1'b1;
                    v_hit           = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Holder view per output: is the current holder still asking for this
    // output, and is its head flit a tail.
    // ------------------------------------------------------------------------
    logic [0:M-1] w_hold_req;
    logic [0:M-1] w_hold_tail;
    logic [0:M-1] w_xfer;

    always_comb begin
        w_hold_req  = '0;
        w_hold_tail = '0;
        for (int m = 0; m < M; m++) begin
            for (int n = 0; n < N; n++) begin
                if (r_sel_val[m] && (r_sel[m] == SEL_W'(n))) begin
                    w_hold_req[m]  = w_req_dec[n][m];
                    w_hold_tail[m] = i_tail[n];
                end
            end
        end
    end

    assign w_xfer = w_hold_req & i_en;

    // Pop is taken from the registered grant, so it lines up with the data
    // the crossbar is steering this cycle.
    always_comb begin
        o_deq = '0;
        for (int m = 0; m < M; m++) begin
            for (int n = 0; n < N; n++) begin
                if (w_xfer[m] && (r_sel[m] == SEL_W'(n))) begin
                    o_deq[n] = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Round-robin search per output, starting at r_ptr and wrapping mod N.
    // ------------------------------------------------------------------------
    logic [0:M-1]            w_arb_hit;
    logic [0:M-1][SEL_W-1:0] w_arb_idx;

    always_comb begin
        int v_idx;
        v_idx     = 0;
        w_arb_hit = '0;
        w_arb_idx = '0;
        for (int m = 0; m < M; m++) begin
            for (int k = 0; k < N; k++) begin
                v_idx = int'(r_ptr[m]) + k;
                if (v_idx >= int'(N)) begin
                    v_idx = v_idx - int'(N);
                end
                if (!w_arb_hit[m] && w_req_dec[v_idx][m]) begin
                    w_arb_hit[m] = 1'b1;
                    w_arb_idx[m] = SEL_W'(v_idx);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Keep decision: when set, output m holds its grant and its pointer.
    // ------------------------------------------------------------------------
    logic [0:M-1] w_keep;

`ifdef ENOC_ALLOC_PACKET_LOCK_EN
    logic [0:M-1] r_lock;
    logic [0:M-1] w_lock_d;

    // Hold on back-pressure, while a packet is open (even if the holder has
    // gone idle), and on a non-tail transfer which opens or continues one.
    assign w_keep = (w_hold_req & ~i_en)
                  | (r_lock & ~(w_xfer & w_hold_tail))
                  | (w_xfer & ~w_hold_tail);

    // A released output always ends up unlocked: release implies either a
    // tail transfer or an idle unlocked output.
    always_comb begin
        w_lock_d = '0;
        for (int m = 0; m < M; m++) begin
            if (w_keep[m]) begin
                w_lock_d[m] = w_xfer[m] ? ~w_hold_tail[m] : r_lock[m];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lock <= '0;
        end else begin
            r_lock <= w_lock_d;
        end
    end
`else
    logic w_unused_tail;

    assign w_unused_tail = ^i_tail;
    assign w_keep        = w_hold_req & ~i_en;
`endif

    // ------------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------------
    always_comb begin
        w_sel_d     = r_sel;
        w_sel_val_d = r_sel_val;
        w_ptr_d     = r_ptr;
        for (int m = 0; m < M; m++) begin
            if (!w_keep[m]) begin
                if (w_arb_hit[m]) begin
                    w_sel_d[m]     = w_arb_idx[m];
                    w_sel_val_d[m] = 1'b1;
                    w_ptr_d[m]     = (w_arb_idx[m] == SEL_W'(N - 1)) ? '0
                                                                    : w_arb_idx[m] + 1'b1;
                end else begin
                    // Select keeps its last value; only the valid drops.
                    w_sel_val_d[m] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_grant_d = '0;
        for (int n = 0; n < N; n++) begin
            for (int m = 0; m < M; m++) begin
                w_grant_d[n][m] = w_sel_val_d[m] && (w_sel_d[m] == SEL_W'(n));
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_grant   <= '0;
            r_sel     <= '0;
            r_sel_val <= '0;
            r_ptr     <= '0;
        end else begin
            r_grant   <= w_grant_d;
            r_sel     <= w_sel_d;
            r_sel_val <= w_sel_val_d;
            r_ptr     <= w_ptr_d;
        end
    end

    assign o_grant   = r_grant;
    assign o_sel     = r_sel;
    assign o_sel_val = r_sel_val;

    // ------------------------------------------------------------------------
    // Invariants: an output is held by at most one input, and a valid select
    // always names an existing input.
    // ------------------------------------------------------------------------
    for (genvar gm = 0; gm < M; gm++) begin : g_chk
        logic [N-1:0] w_col;

        always_comb begin
            w_col = '0;
            for (int n = 0; n < N; n++) begin
                w_col[n] = r_grant[n][gm];
            end
        end

        a_one_holder : assert property (@(posedge clk) disable iff (!reset_n)
            $onehot0(w_col));
        a_sel_range : assert property (@(posedge clk) disable iff (!reset_n)
            r_sel_val[gm] |-> (32'(r_sel[gm]) < N));
    end

endmodule

// File: tb/tb_enoc_switch_allocator.sv
// ----------------------------------------------------------------------------
// tb_enoc_switch_allocator
//
// Self-checking bench for enoc_switch_allocator (N = M = 5). Covers reset,
// a table of directed steps (single request, round-robin wrap, parallel
// outputs), back-pressure, async reset mid-transfer, packet interleave vs.
// wormhole lock (ENOC_ALLOC_PACKET_LOCK_EN), and randomized traffic checked
// against a holder/pointer reference model.
// ----------------------------------------------------------------------------
module tb_enoc_switch_allocator;

    localparam int N  = 5;
    localparam int M  = 5;
    localparam int SW = 3;
    localparam logic [2:0] X = 3'd7;  // "no holder" in the table

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic [0:N-1]             req;
    logic [0:N-1][0:M-1]      req_out;
    logic [0:N-1]             tail;
    logic [0:M-1]             en;
    logic [0:N-1][0:M-1]      grant;
    logic [0:M-1][SW-1:0]     sel;
    logic [0:M-1]             sel_val;
    logic [0:N-1]             deq;

    int errs   = 0;
    int checks = 0;

    enoc_switch_allocator #(
        .N (N),
        .M (M)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_req     (req),
        .i_req_out (req_out),
        .i_tail    (tail),
        .i_en      (en),
        .o_grant   (grant),
        .o_sel     (sel),
        .o_sel_val (sel_val),
        .o_deq     (deq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: holder per output (-1 = none), pointer, lock flag.
    // ------------------------------------------------------------------------
    int m_hold [M];
    int m_ptr  [M];
    bit m_lock [M];

    function automatic int dec(input int n);
        if (!req[n]) return -1;
        for (int m = 0; m < M; m++) if (req_out[n][m]) return m;
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < M; m++) begin
            m_hold[m] = -1;
            m_ptr[m]  = 0;
            m_lock[m] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int m = 0; m < M; m++) begin
            int h;
            bit hreq, x, keep;
            h    = m_hold[m];
            keep = 1'b0;
            if (h >= 0) begin
                hreq = (dec(h) == m);
                x    = hreq && en[m];
`ifdef ENOC_ALLOC_PACKET_LOCK_EN
                keep = (hreq && !en[m]) || (m_lock[m] && !(x && tail[h])) || (x && !tail[h]);
                m_lock[m] = keep && (x ? !tail[h] : m_lock[m]);
`else
                keep = hreq && !en[m];
`endif
            end
            if (!keep) begin
                m_hold[m] = -1;
                for (int k = 0; k < N; k++) begin
                    int w;
                    w = (m_ptr[m] + k) % N;
                    if (m_hold[m] < 0 && dec(w) == m) begin
                        m_hold[m] = w;
                        m_ptr[m]  = (w + 1) % N;
                    end
                end
            end
        end
    endtask

    task automatic model_check(input string tag);
        logic [0:N-1][0:M-1]  eg;
        logic [0:M-1]         ev;
        logic [0:N-1]         ed;
        logic [0:M-1][SW-1:0] es, as;
        eg = '0; ev = '0; ed = '0; es = '0; as = '0;
        for (int m = 0; m < M; m++) begin
            if (m_hold[m] >= 0) begin
                eg[m_hold[m]][m] = 1'b1;
                ev[m]            = 1'b1;
                es[m]            = SW'(m_hold[m]);
                as[m]            = sel[m];
                if (dec(m_hold[m]) == m && en[m]) ed[m_hold[m]] = 1'b1;
            end
        end
        check({tag, "_grant"}, 64'(grant), 64'(eg));
        check({tag, "_selval"}, 64'(sel_val), 64'(ev));
        check({tag, "_sel"}, 64'(as), 64'(es));
        check({tag, "_deq"}, 64'(deq), 64'(ed));
    endtask

    task automatic do_reset();
        req     = '0;
        req_out = '0;
        tail    = '0;
        en      = '0;
        reset_n = 1'b0;
        #2;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Directed table: inputs, then expected holder per output and deq.
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [0:N-1]       req;
        logic [0:N-1][2:0]  dst;
        logic [0:M-1]       en;
        logic [0:M-1][2:0]  hold;
        logic [0:N-1]       deq;
    } vec_t;

    vec_t tbl [14];
    int   q_deq [$];
    int   exp_pkt [8];

    initial begin
        // ---------------- reset state with busy inputs ----------------
        reset_n = 1'b0;
        req     = '1;
        req_out = '1;
        tail    = '0;
        en      = '1;
        #22;
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_sel", 64'(sel), 64'd0);
        check("rst_selval", 64'(sel_val), 64'd0);
        check("rst_deq", 64'(deq), 64'd0);

        // ---------------- table-driven steps ----------------
        tbl[0]  = '{req: 5'b00010, dst: {3'd0, 3'd0, 3'd0, 3'd4, 3'd0}, en: 5'b11111,
                    hold: {X, X, X, X, X}, deq: 5'b00000};
        tbl[1]  = '{req: 5'b00010, dst: {3'd0, 3'd0, 3'd0, 3'd4, 3'd0}, en: 5'b11111,
                    hold: {X, X, X, X, 3'd3}, deq: 5'b00010};
        tbl[2]  = '{req: 5'b00000, dst: {3'd0, 3'd0, 3'd0, 3'd4, 3'd0}, en: 5'b11111,
                    hold: {X, X, X, X, 3'd3}, deq: 5'b00000};
        tbl[3]  = '{req: 5'b00000, dst: {3'd0, 3'd0, 3'd0, 3'd4, 3'd0}, en: 5'b11111,
                    hold: {X, X, X, X, X}, deq: 5'b00000};
        tbl[4]  = '{req: 5'b11001, dst: {3'd2, 3'd2, 3'd0, 3'd0, 3'd2}, en: 5'b11111,
                    hold: {X, X, X, X, X}, deq: 5'b00000};
        tbl[5]  = '{req: 5'b11001, dst: {3'd2, 3'd2, 3'd0, 3'd0, 3'd2}, en: 5'b11111,
                    hold: {X, X, 3'd0, X, X}, deq: 5'b10000};
        tbl[6]  = '{req: 5'b11001, dst: {3'd2, 3'd2, 3'd0, 3'd0, 3'd2}, en: 5'b11111,
                    hold: {X, X, 3'd1, X, X}, deq: 5'b01000};
        tbl[7]  = '{req: 5'b11001, dst: {3'd2, 3'd2, 3'd0, 3'd0, 3'd2}, en: 5'b11111,
                    hold: {X, X, 3'd4, X, X}, deq: 5'b00001};
        tbl[8]  = '{req: 5'b11001, dst: {3'd2, 3'd2, 3'd0, 3'd0, 3'd2}, en: 5'b11111,
                    hold: {X, X, 3'd0, X, X}, deq: 5'b10000};
        tbl[9]  = '{req: 5'b11001, dst: {3'd2, 3'd2, 3'd0, 3'd0, 3'd2}, en: 5'b11111,
                    hold: {X, X, 3'd1, X, X}, deq: 5'b01000};
        tbl[10] = '{req: 5'b11001, dst: {3'd2, 3'd2, 3'd0, 3'd0, 3'd2}, en: 5'b11111,
                    hold: {X, X, 3'd4, X, X}, deq: 5'b00001};
        tbl[11] = '{req: 5'b11111, dst: {3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, en: 5'b11111,
                    hold: {X, X, 3'd0, X, X}, deq: 5'b00000};
        tbl[12] = '{req: 5'b11111, dst: {3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, en: 5'b11111,
                    hold: {3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, deq: 5'b11111};
        tbl[13] = '{req: 5'b11111, dst: {3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, en: 5'b11111,
                    hold: {3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, deq: 5'b11111};

        do_reset();
        for (int i = 0; i < 14; i++) begin
            logic [0:N-1][0:M-1] eg;
            req  = tbl[i].req;
            en   = tbl[i].en;
            tail = '1;
            for (int n = 0; n < N; n++) begin
                req_out[n] = '0;
                req_out[n][tbl[i].dst[n]] = 1'b1;
            end
            eg = '0;
            for (int m = 0; m < M; m++) if (tbl[i].hold[m] != X) eg[tbl[i].hold[m]][m] = 1'b1;
            #1;
            check($sformatf("tbl%0d_grant", i), 64'(grant), 64'(eg));
            check($sformatf("tbl%0d_deq", i), 64'(deq), 64'(tbl[i].deq));
            @(posedge clk);
            #1;
        end

        // ---------------- back-pressure ----------------
        do_reset();
        tail       = '1;
        en         = '1;
        req        = 5'b01000;
        req_out[1] = 5'b00010;
        @(posedge clk);
        #1;
        req        = 5'b01100;
        req_out[2] = 5'b00010;
        en[3]      = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_hold_sel", 64'({sel_val[3], sel[3]}), 64'({1'b1, 3'd1}));
            check("bp_hold_deq", 64'(deq), 64'd0);
            @(posedge clk);
            #1;
        end
        en[3] = 1'b1;
        #1;
        check("bp_release_deq", 64'(deq), 64'(5'b01000));
        @(posedge clk);
        #1;
        check("bp_next_sel", 64'({sel_val[3], sel[3]}), 64'({1'b1, 3'd2}));
        check("bp_next_deq", 64'(deq), 64'(5'b00100));

        // ---------------- async reset mid-transfer ----------------
        do_reset();
        tail       = '1;
        en         = '1;
        req        = 5'b00100;
        req_out[2] = 5'b01000;
        @(posedge clk);
        #1;
        check("mid_grant21", 64'(grant[2][1]), 64'd1);
        check("mid_deq2", 64'(deq), 64'(5'b00100));
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_grant", 64'(grant), 64'd0);
        check("mid_rst_selval", 64'({sel, sel_val}), 64'd0);
        check("mid_rst_deq", 64'(deq), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("mid_post_idle", 64'(sel_val), 64'd0);
        @(posedge clk);
        #1;
        check("mid_regrant", 64'(grant[2][1]), 64'd1);

        // ---------------- 4-flit packet vs. competing input ----------------
        do_reset();
        en         = '1;
        req_out[0] = 5'b01000;
        req_out[2] = 5'b01000;
        begin
            int rem0;
            rem0 = 4;
            for (int c = 0; c < 20; c++) begin
                req[0]  = (rem0 > 0);
                req[2]  = 1'b1;
                tail[0] = (rem0 == 1);
                tail[2] = 1'b1;
                #1;
                if (deq[0]) begin
                    q_deq.push_back(0);
                    rem0--;
                end
                if (deq[2]) q_deq.push_back(2);
                @(posedge clk);
                #1;
            end
        end
`ifdef ENOC_ALLOC_PACKET_LOCK_EN
        exp_pkt = '{0, 0, 0, 0, 2, 2, 2, 2};
`else
        exp_pkt = '{0, 2, 0, 2, 0, 2, 0, 2};
`endif
        check("pkt_count_ok", 64'(q_deq.size() >= 8), 64'd1);
        for (int i = 0; i < 8; i++) begin
            if (i < q_deq.size()) check($sformatf("pkt_order%0d", i), 64'(q_deq[i]),
                                        64'(exp_pkt[i]));
        end

        // ---------------- randomized vs. reference model ----------------
        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            if (c == 300) begin
                do_reset();
                model_reset();
            end
            for (int n = 0; n < N; n++) begin
                if ($urandom_range(0, 99) < 40) req[n] = ($urandom_range(0, 99) < 70);
                if ($urandom_range(0, 99) < 30) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req_out[n] = 5'($urandom);
                    end else begin
                        int d;
                        d          = $urandom_range(0, M - 1);
                        req_out[n] = '0;
                        req_out[n][d] = 1'b1;
                    end
                end
                tail[n] = ($urandom_range(0, 99) < 35);
            end
            for (int m = 0; m < M; m++) en[m] = ($urandom_range(0, 99) < 70);
            #1;
            model_check("rand");
            model_edge();
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/enoc_switch_allocator.md
Name: enoc_switch_allocator

Overview:
- Per-router switch allocator for the ENoC 2D mesh/torus router.
- Shares each of the M router output ports (local, N, E, S, W) among N input queues using round-robin arbitration.
- Produces registered one-hot grants per output, and a binary select for the output crossbar mux.
- Stalls grants on the downstream enable of the valid/enable protocol, so an input keeps its grant across back-pressure.

Parameters:
- N, 5, number of input queues (requesters).
- M, 5, number of output ports (resources).
- SEL_W, log2(N), width of the per-output select index. Derived; do not override.

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- i_req, input, [0:N-1], input n has a head flit valid at its queue.
- i_req_out, input, [0:N-1][0:M-1], one-hot output port requested by input n (from the routing calculation). Only meaningful when i_req[n]=1.
- i_tail, input, [0:N-1], the head flit of input n is a packet tail. Used only with the optional feature.
- i_en, input, [0:M-1], downstream enable for output m.
- o_grant, output, [0:N-1][0:M-1], registered grant of output m to input n.
- o_sel, output, [0:M-1][SEL_W-1:0], index of the input currently granted output m (crossbar mux select).
- o_sel_val, output, [0:M-1], output m has a valid grant.
- o_deq, output, [0:N-1], input n pops its queue this cycle.

Behaviour:
- Reset:
  - o_grant, o_sel, o_sel_val and o_deq are all 0.
  - Every round-robin pointer ptr[m] is 0.
  - The lock flags are clear.
  - Reset is async assert; outputs clear immediately, mid-transfer included, and no flit is transferred.
- Request decode: if i_req_out[n] has more than one bit set, only the lowest-index set bit is honoured. i_req_out is ignored when i_req[n]=0.
- Transfer condition: xfer[m] = o_sel_val[m] & i_req[o_sel[m]] & i_req_out[o_sel[m]][m] & i_en[m].
- o_deq[n] = OR over m of (xfer[m] & o_sel[m]==n). This is combinational from the registered grant, so data and deq happen in the same cycle.
- Per-output update at each clk edge:
  - Stall: if o_sel_val[m]=1, the holder is still requesting m, and i_en[m]=0, hold the grant unchanged and leave ptr[m] unchanged.
  - Arbitrate: otherwise, search the requesters to m from ptr[m] upward, modulo N.
    - First hit w: grant w, set o_sel[m]=w, o_sel_val[m]=1, and ptr[m]=(w+1) mod N.
    - No hit: o_sel_val[m]=0 and ptr[m] unchanged.
  - Holder withdrawal: if the holder drops i_req or changes its requested output, the grant is released the next edge and arbitration proceeds.
- Latency: request to grant visible is 1 cycle. Grant to transfer is 0 cycles when i_en is high.
- Throughput: 1 flit per output per cycle with continuous requests.
- One output per input: an input requests one output at a time, so it never holds two grants.
- Fairness: with all N inputs requesting one output, each is granted once every N transfers.
- ptr wrap: ptr = N-1 followed by a win at N-1 wraps to 0.

Optional Feature:
- Macro: ENOC_ALLOC_PACKET_LOCK_EN.
- Defined (wormhole lock):
  - After a grant whose transfer carries i_tail=0, output m sets lock[m].
  - While locked, the holder keeps the grant even with i_en high, and ptr[m] is not advanced.
  - The lock clears on the transfer with i_tail=1; arbitration resumes at the next edge.
  - If the holder drops i_req while locked, the grant is held with no transfer.
- Undefined: i_tail is ignored, no lock state is synthesised, and the output re-arbitrates after every transfer (flit-level arbitration).

Test Plan:
- Bench default is N=M=5, macro undefined unless stated.
- Reset: assert reset_n=0 mid-transfer with o_grant[2][1]=1 -> all outputs 0 immediately; after release, input 2 re-requesting output 1 gets the grant 1 cycle later.
- Single request: input 3 requests output 4 with i_en[4]=1 -> o_grant[3][4]=1, o_sel[4]=3 the next cycle, o_deq[3]=1 the same cycle; ptr[4]=4.
- Round-robin: inputs 0,1,4 continuously request output 2 with i_en=1 -> grant order 0,1,4,0,1,4; ptr wraps to 0 after 4 wins.
- Back-pressure: input 1 holds output 3 and i_en[3]=0 for 3 cycles while input 2 also requests -> grant stays on 1 with o_deq[1]=0; on i_en[3]=1, input 1 transfers, then input 2 is granted.
- Parallel outputs: inputs 0..4 request outputs 4,3,2,1,0 respectively -> all 5 grants in the same cycle and 5 deqs per cycle sustained.
- Macro defined: input 0 sends a 4-flit packet (tail on flit 4) to output 1 while input 2 also requests -> input 2 is granted only after the tail transfer. The same stimulus with the macro undefined interleaves inputs 0 and 2.
